// File: rtl/alu_pkg.sv
// Shared definitions for the operand issue stage and the ALU it feeds.
//   XLEN     : datapath width
//   NREG     : architectural register count (x0 reads as zero)
//   regidx_t : register index type
//   aluop_t  : ALU operation code; encodings follow the RV32 funct3 values
//   src_hazard / bypass_hit : helpers shared by the issue logic
package alu_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  typedef logic [4:0]      regidx_t;
  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_XOR = 3'b100,
    ALU_OR  = 3'b110
  } aluop_t;

  // A source waits only while its producer is outstanding and the result
  // is not arriving on the writeback port this very cycle.
  function automatic logic src_hazard(input regidx_t         s,
                                      input logic [NREG-1:0] pend,
                                      input logic            wb_en,
                                      input regidx_t         wb_rd);
    return (s != '0) && pend[s] && !(wb_en && (wb_rd == s));
  endfunction

  // Writeback forwarding applies to real registers only; x0 stays zero.
  function automatic logic bypass_hit(input regidx_t s,
                                      input logic    wb_en,
                                      input regidx_t wb_rd);
    return wb_en && (wb_rd == s) && (s != '0);
  endfunction

endpackage

// File: rtl/operand_issue_if.sv
// Bus between the decoder, the operand issue stage and the ALU.
//   in_*  : decoded operation from upstream (in_valid/in_ready handshake)
//   out_* : registered operands to the ALU (out_valid/out_ready handshake)
//   wb_*  : ALU result writeback strobe, index and data
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid && ready are both 1. The producer keeps its payload stable
// while valid && !ready; ready never depends on valid in the same cycle.
interface operand_issue_if;
  import alu_pkg::*;

  logic    in_valid;
  logic    in_ready;
  regidx_t in_rs1;
  regidx_t in_rs2;
  regidx_t in_rd;
  xlen_t   in_imm;
  logic    in_use_imm;
  aluop_t  in_aluop;

  logic    out_valid;
  logic    out_ready;
  xlen_t   out_ain;
  xlen_t   out_bin;
  aluop_t  out_aluop;
  regidx_t out_rd;

  logic    wb_en;
  regidx_t wb_rd;
  xlen_t   wb_data;

  // The issue stage itself.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_aluop,
    output in_ready,
    output out_valid, out_ain, out_bin, out_aluop, out_rd,
    input  out_ready,
    input  wb_en, wb_rd, wb_data
  );

  // Everything around it: decoder, ALU and writeback source.
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_imm, in_use_imm, in_aluop,
    input  in_ready,
    input  out_valid, out_ain, out_bin, out_aluop, out_rd,
    output out_ready,
    output wb_en, wb_rd, wb_data
  );

endinterface

// File: rtl/operand_issue_regfile.sv
// Architectural register file: two combinational read ports, one write port.
//   clk, rst_n          : clock and asynchronous active-low reset
//   i_raddr1/o_rdata1   : read port 1
//   i_raddr2/o_rdata2   : read port 2
//   i_we/i_waddr/i_wdata: write port, written at the rising edge
// x0 reads as zero and writes to it are dropped.
module operand_issue_regfile
  import alu_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  regidx_t i_raddr1,
  output xlen_t   o_rdata1,
  input  regidx_t i_raddr2,
  output xlen_t   o_rdata2,
  input  logic    i_we,
  input  regidx_t i_waddr,
  input  xlen_t   i_wdata
);

  xlen_t r_regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/operand_issue.sv
// Operand issue stage in front of the execute ALU.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : operand_issue_if.slave (decoded op in, operands out,
//                ALU result writeback in)
//   o_pending  : scoreboard of registers with an outstanding write
//
// An op is accepted when the output register can load (empty or being
// drained) and none of its sources, nor its destination, has an
// outstanding write that is not being retired this cycle. A writeback in
// the same cycle is forwarded straight into the operands.
module operand_issue
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  operand_issue_if.slave  bus,
  output logic [NREG-1:0] o_pending
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;

  logic    r_out_valid;
  xlen_t   r_out_ain;
  xlen_t   r_out_bin;
  aluop_t  r_out_aluop;
  regidx_t r_out_rd;

  xlen_t w_rf_rdata1;
  xlen_t w_rf_rdata2;
  xlen_t w_rs1_val;
  xlen_t w_rs2_val;

  logic w_hz_rs1;
  logic w_hz_rs2;
  logic w_hz_rd;
  logic w_hazard;
  logic w_ld;
  logic w_in_ready;
  logic w_accept;

  operand_issue_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (bus.in_rs1),
    .o_rdata1 (w_rf_rdata1),
    .i_raddr2 (bus.in_rs2),
    .o_rdata2 (w_rf_rdata2),
    .i_we     (bus.wb_en),
    .i_waddr  (bus.wb_rd),
    .i_wdata  (bus.wb_data)
  );

  // Hazard detection. rs2 only matters when the op actually reads it; rd
  // is checked so a second write cannot overtake the first (WAW).
  always_comb begin
    w_hz_rs1 = src_hazard(bus.in_rs1, r_pending, bus.wb_en, bus.wb_rd);
    w_hz_rs2 = src_hazard(bus.in_rs2, r_pending, bus.wb_en, bus.wb_rd);
    w_hz_rd  = src_hazard(bus.in_rd,  r_pending, bus.wb_en, bus.wb_rd);
    w_hazard = w_hz_rs1 || (!bus.in_use_imm && w_hz_rs2) || w_hz_rd;
  end

  // ld: output register is free or its contents leave this cycle.
  // rst_n gates ready so nothing is offered as accepted while in reset.
  assign w_ld       = !r_out_valid || bus.out_ready;
  assign w_in_ready = rst_n && w_ld && !w_hazard;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Operand muxes with writeback forwarding.
  always_comb begin
    w_rs1_val = w_rf_rdata1;
    if (bypass_hit(bus.in_rs1, bus.wb_en, bus.wb_rd)) begin
      w_rs1_val = bus.wb_data;
    end
    w_rs2_val = w_rf_rdata2;
    if (bypass_hit(bus.in_rs2, bus.wb_en, bus.wb_rd)) begin
      w_rs2_val = bus.wb_data;
    end
  end

  // Scoreboard update. The set for a newly accepted op is applied after
  // the writeback clear so it wins when both hit the same register.
  always_comb begin
    w_pending_nxt = r_pending;
    if (bus.wb_en) begin
      w_pending_nxt[bus.wb_rd] = 1'b0;
    end
    if (w_accept && (bus.in_rd != '0)) begin
      w_pending_nxt[bus.in_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Output register. Data only changes on accept, so it holds while the
  // ALU stalls and keeps its last value after the op drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_ain   <= '0;
      r_out_bin   <= '0;
      r_out_aluop <= ALU_ADD;
      r_out_rd    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_ain   <= w_rs1_val;
      r_out_bin   <= bus.in_use_imm ? bus.in_imm : w_rs2_val;
      r_out_aluop <= bus.in_aluop;
      r_out_rd    <= bus.in_rd;
    end else if (w_ld) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_ain   = r_out_ain;
  assign bus.out_bin   = r_out_bin;
  assign bus.out_aluop = r_out_aluop;
  assign bus.out_rd    = r_out_rd;
  assign o_pending     = r_pending;

endmodule

// File: doc/operand_issue.md
# operand_issue

Operand issue stage directly upstream of the execute ALU. Accepts decoded register-register and register-immediate operations over a valid/ready handshake and reads rs1 and rs2 from an internal 32-entry register file. Resolves read-after-write and write-after-write hazards with a pending-write scoreboard plus a writeback bypass. Presents registered Ain/Bin/ALUop/rd to the ALU, and takes the ALU result back on a writeback port.

## Interface
- XLEN, 32, datapath width
- NREG, 32, number of architectural registers; x0 is hardwired to zero
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded operation available
- in_ready  out  1  stage accepts the operation this cycle
- in_rs1, in_rs2, in_rd  in  5 each  source and destination register indices
- in_imm  in  XLEN  immediate operand
- in_use_imm  in  1  1: Bin = in_imm; 0: Bin = rs2 value
- in_aluop  in  3  ALU operation code (ADD/XOR/OR encodings)
- out_valid  out  1  issued operation held on the out_* bus
- out_ready  in  1  ALU stage consumes the operation this cycle
- out_ain, out_bin  out  XLEN  operands for the ALU
- out_aluop  out  3  registered copy of in_aluop
- out_rd  out  5  destination register, carried forward
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback register index
- wb_data  in  XLEN  writeback value (the ALU result)

## Operation
- Register file: 2 combinational read ports, 1 write port. A read of x0 returns 0. A write to x0 is dropped.
- Scoreboard: pending[NREG-1:0].
  - On a writeback with wb_en=1, pending[wb_rd] is cleared. This happens even if the bit was not set.
  - On an accept with in_rd≠0, pending[in_rd] is set.
  - pending[0] is always 0.
- Effective hazard on source s: s≠0 && pending[s] && !(wb_en && wb_rd==s).
- Hazard = hazard(rs1), OR hazard(rs2) when in_use_imm=0, OR the effective hazard on rd (WAW stall).
- Bypass: if wb_en && wb_rd==s && s≠0, the operand is wb_data, not the register file value.
- Load condition: ld = !out_valid || out_ready.
- in_ready = ld && !hazard. An accept occurs when in_valid && in_ready.
- On accept, the output register loads:
  - out_ain = rs1 value (bypassed)
  - out_bin = in_use_imm ? in_imm : rs2 value (bypassed)
  - out_aluop and out_rd from the inputs
  - out_valid = 1
- If ld=1 and there is no accept, out_valid = 0. The out_* data holds its last value.
- Same-cycle writeback to X and accept with rd=X: the set wins, so pending[X] ends at 1. The register file still takes wb_data.
- in_ready does not depend on in_valid (no combinational loop). out_* is stable while out_valid && !out_ready.

## Timing
- Reset, asynchronous: out_valid=0; out_ain/out_bin=0; out_aluop=0; out_rd=0; pending=0; all registers=0.
- in_ready is 0 during reset; it may be 1 from the first cycle after deassertion.
- Reset asserted mid-operation discards the held output and all pending bits immediately.
- Latency: an operation accepted at edge N is visible on out_* with out_valid=1 after edge N.
- Throughput is 1 per cycle when there are no hazards and out_ready=1.
- Writeback: the register file write and the pending clear both occur at the edge where wb_en=1.
- A dependent operation may issue in the same cycle as its writeback, via the bypass.
- Back-pressure: while out_valid && !out_ready, in_ready=0 and the scoreboard is unchanged except for writeback clears.

## Structure
- Shared package alu_pkg:
  - aluop_t (3-bit enum ADD/XOR/OR, encodings identical to the existing ADD/XOR/OR macros)
  - XLEN
  - reg index type regidx_t (5-bit)
- Sub-module regfile: 2 read ports, 1 write port, x0 hardwired, asynchronous active-low reset. Instantiated once.
- Scoreboard, bypass muxes and the output register live in the top module.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, all outputs 0. Release -> in_ready=1 on the next cycle.
- Immediate op: issue rs1=0, imm=32'h0000_0005, use_imm=1, ADD, rd=3 -> one cycle later out_ain=0, out_bin=5, out_rd=3, out_valid=1, pending[3]=1.
- RAW stall: op A with rd=3 pending, then op B with rs1=3 -> in_ready=0 until wb_rd=3, wb_data=32'hDEAD_BEEF. In that same cycle B is accepted, and next cycle out_ain=32'hDEAD_BEEF.
- WAW and same-cycle set/clear:
  - Writeback to rd=5 coincides with issue of a new rd=5 op -> pending[5]=1 afterwards, and a later read of r5 returns the written data.
  - Issue to pending rd=6 -> stalled.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready=0. When out_ready=1, the next queued op loads the same cycle.
- x0: wb_rd=0 with wb_data=32'hFFFF_FFFF, then issue rs1=0 -> out_ain=0. An op with rd=0 never stalls later readers.
